// File: rtl/cond_logic_pkg.sv
// Purpose: shared ARM control-unit constants (condition codes, flag and FlagW bit positions).
// Latency: n/a (constants only).
// Backpressure: n/a.
package cond_logic_pkg;

    // Instruction condition field encodings, Instr[31:28]
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    // Bit positions inside the {N,Z,C,V} flag vector
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Bit positions inside the decoder's FlagW enable
    localparam int FLAGW_NZ = 1;
    localparam int FLAGW_CV = 0;

endpackage

// File: rtl/cond_logic_cond_check.sv
// Purpose: decode the ARM condition field against {N,Z,C,V}; ports cond, flags -> cond_ex.
// Latency: purely combinational, zero cycles.
// Backpressure: none; no state.
module cond_check
    import cond_logic_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = ~z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = ~c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = ~n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = ~v;
            COND_HI: cond_ex = c & ~z;
            COND_LS: cond_ex = ~c | z;
            COND_GE: cond_ex = ~(n ^ v);
            COND_LT: cond_ex = n ^ v;
            COND_GT: cond_ex = ~z & ~(n ^ v);
            COND_LE: cond_ex = z | (n ^ v);
            COND_AL: cond_ex = 1'b1;
            COND_NV: cond_ex = 1'b0;   // reserved encoding never executes
            default: cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_logic.sv
// Purpose: NZCV flag register, condition evaluation and gating of PCS/RegW/MemW strobes.
// Latency: strobes and CondEx combinational; Flags/CondExQ update one clk after the write.
// Backpressure: InstrEn=0 stalls (no flag write, no strobes); CondExQ still follows CondLatch.
// Ports: Cond/ALUFlags/FlagW/PCS/RegW/MemW/NoWrite/InstrEn/CondLatch in;
//        PCSrc/RegWrite/MemWrite strobes, Flags, CondEx, CondExQ out.
module cond_logic
    import cond_logic_pkg::*;
#(
    parameter logic [3:0] FLAG_RESET = 4'b0000,
    parameter bit         MULTICYCLE = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       PCS,
    input  logic       RegW,
    input  logic       MemW,
    input  logic       NoWrite,
    input  logic       InstrEn,
    input  logic       CondLatch,
    output logic       PCSrc,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic [3:0] Flags,
    output logic       CondEx,
    output logic       CondExQ
);

    logic [3:0] flags_q;
    logic       cond_ex_q;
    logic       gate;

    // Evaluated on the stored (pre-update) flags; ALUFlags is never forwarded.
    cond_check u_cond_check (
        .cond    (Cond),
        .flags   (flags_q),
        .cond_ex (CondEx)
    );

    // Multicycle controllers decode once and execute over several cycles,
    // so they gate with the value captured at decode rather than the live one.
    assign gate = (MULTICYCLE ? cond_ex_q : CondEx) & InstrEn;

    assign PCSrc    = PCS  & gate;
    assign RegWrite = RegW & gate & ~NoWrite;
    assign MemWrite = MemW & gate;

    // N,Z and C,V halves are written independently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= FLAG_RESET;
        end else begin
            if (gate & FlagW[FLAGW_NZ]) begin
                flags_q[FLAG_N] <= ALUFlags[FLAG_N];
                flags_q[FLAG_Z] <= ALUFlags[FLAG_Z];
            end
            if (gate & FlagW[FLAGW_CV]) begin
                flags_q[FLAG_C] <= ALUFlags[FLAG_C];
                flags_q[FLAG_V] <= ALUFlags[FLAG_V];
            end
        end
    end

    // Captures CondEx from the old flags even when a flag write lands in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cond_ex_q <= 1'b0;
        end else if (CondLatch) begin
            cond_ex_q <= CondEx;
        end
    end

    assign Flags   = flags_q;
    assign CondExQ = cond_ex_q;

endmodule

// File: tb/tb_cond_logic.sv
module tb_cond_logic;

    logic       clk;
    logic       rst_n;
    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    logic [1:0] FlagW;
    logic       PCS, RegW, MemW, NoWrite, InstrEn, CondLatch;

    // single-cycle instance (_s) and multicycle instance (_m) share all inputs
    logic       PCSrc_s, RegWrite_s, MemWrite_s, CondEx_s, CondExQ_s;
    logic [3:0] Flags_s;
    logic       PCSrc_m, RegWrite_m, MemWrite_m, CondEx_m, CondExQ_m;
    logic [3:0] Flags_m;

    int n_cmp  = 0;
    int n_fail = 0;

    // behavioural model state
    logic [3:0] m_flags_s, m_flags_m;
    logic       m_q_s, m_q_m;

    cond_logic #(.FLAG_RESET(4'b0000), .MULTICYCLE(1'b0)) dut_s (
        .clk(clk), .rst_n(rst_n), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
        .PCS(PCS), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite), .InstrEn(InstrEn),
        .CondLatch(CondLatch), .PCSrc(PCSrc_s), .RegWrite(RegWrite_s),
        .MemWrite(MemWrite_s), .Flags(Flags_s), .CondEx(CondEx_s), .CondExQ(CondExQ_s)
    );

    cond_logic #(.FLAG_RESET(4'b0000), .MULTICYCLE(1'b1)) dut_m (
        .clk(clk), .rst_n(rst_n), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
        .PCS(PCS), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite), .InstrEn(InstrEn),
        .CondLatch(CondLatch), .PCSrc(PCSrc_m), .RegWrite(RegWrite_m),
        .MemWrite(MemWrite_m), .Flags(Flags_m), .CondEx(CondEx_m), .CondExQ(CondExQ_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ARM-style reference: bits [3:1] pick a base predicate, bit 0 inverts it.
    function automatic logic ref_pass(input logic [3:0] cnd, input logic [3:0] f);
        logic n, z, c, v, base;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        case (cnd[3:1])
            3'd0: base = z;
            3'd1: base = c;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = c && !z;
            3'd5: base = (n == v);
            3'd6: base = (n == v) && !z;
            default: base = 1'b1;
        endcase
        if (cnd == 4'b1111) return 1'b0;
        return base ^ cnd[0];
    endfunction

    function automatic logic [3:0] ref_update(input logic [3:0] f, input logic g,
                                              input logic [1:0] fw, input logic [3:0] alu);
        logic [3:0] r;
        r = f;
        if (g && fw[1]) r[3:2] = alu[3:2];
        if (g && fw[0]) r[1:0] = alu[1:0];
        return r;
    endfunction

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // compare every output of both instances against the model
    task automatic check_all(input string tag);
        logic g_s, g_m;
        g_s = ref_pass(Cond, m_flags_s) & InstrEn;
        g_m = m_q_m & InstrEn;
        chk({tag, " flags_s"},   Flags_s,    m_flags_s);
        chk({tag, " condex_s"},  CondEx_s,   ref_pass(Cond, m_flags_s));
        chk({tag, " condexq_s"}, CondExQ_s,  m_q_s);
        chk({tag, " pcsrc_s"},   PCSrc_s,    PCS & g_s);
        chk({tag, " regwr_s"},   RegWrite_s, RegW & g_s & !NoWrite);
        chk({tag, " memwr_s"},   MemWrite_s, MemW & g_s);
        chk({tag, " flags_m"},   Flags_m,    m_flags_m);
        chk({tag, " condex_m"},  CondEx_m,   ref_pass(Cond, m_flags_m));
        chk({tag, " condexq_m"}, CondExQ_m,  m_q_m);
        chk({tag, " pcsrc_m"},   PCSrc_m,    PCS & g_m);
        chk({tag, " regwr_m"},   RegWrite_m, RegW & g_m & !NoWrite);
        chk({tag, " memwr_m"},   MemWrite_m, MemW & g_m);
    endtask

    // advance one clock; model state follows the inputs present before the edge
    task automatic tick();
        logic [3:0] nf_s, nf_m;
        logic       nq_s, nq_m, g_s, g_m;
        g_s  = ref_pass(Cond, m_flags_s) & InstrEn;
        g_m  = m_q_m & InstrEn;
        nf_s = ref_update(m_flags_s, g_s, FlagW, ALUFlags);
        nf_m = ref_update(m_flags_m, g_m, FlagW, ALUFlags);
        nq_s = CondLatch ? ref_pass(Cond, m_flags_s) : m_q_s;
        nq_m = CondLatch ? ref_pass(Cond, m_flags_m) : m_q_m;
        @(posedge clk);
        #1;
        m_flags_s = nf_s; m_flags_m = nf_m;
        m_q_s = nq_s; m_q_m = nq_m;
    endtask

    task automatic idle();
        Cond = 4'b1110; ALUFlags = 4'b0000; FlagW = 2'b00;
        PCS = 1'b0; RegW = 1'b0; MemW = 1'b0; NoWrite = 1'b0;
        InstrEn = 1'b1; CondLatch = 1'b0;
    endtask

    // load both instances with flags v and leave CondExQ=1 (AL latched)
    task automatic set_flags(input logic [3:0] v);
        idle();
        CondLatch = 1'b1;
        tick();
        CondLatch = 1'b0; FlagW = 2'b11; ALUFlags = v;
        tick();
        idle();
    endtask

    typedef struct {
        logic [3:0] flags;
        logic [3:0] cond;
        logic       exp;
    } vec_t;

    vec_t tbl[$];

    initial begin
        tbl = '{
            '{4'b0000, 4'b0000, 1'b0}, '{4'b0100, 4'b0000, 1'b1}, '{4'b0100, 4'b0001, 1'b0},
            '{4'b0010, 4'b0010, 1'b1}, '{4'b0000, 4'b0011, 1'b1}, '{4'b1000, 4'b0100, 1'b1},
            '{4'b1000, 4'b0101, 1'b0}, '{4'b0001, 4'b0110, 1'b1}, '{4'b0001, 4'b0111, 1'b0},
            '{4'b0010, 4'b1000, 1'b1}, '{4'b0110, 4'b1000, 1'b0}, '{4'b0110, 4'b1001, 1'b1},
            '{4'b1001, 4'b1010, 1'b1}, '{4'b1001, 4'b1011, 1'b0}, '{4'b1001, 4'b1100, 1'b1},
            '{4'b1001, 4'b1101, 1'b0}, '{4'b1000, 4'b1010, 1'b0}, '{4'b1100, 4'b1100, 1'b0},
            '{4'b1100, 4'b1101, 1'b1}, '{4'b0000, 4'b1110, 1'b1}, '{4'b1111, 4'b1111, 1'b0}
        };

        rst_n = 1'b0;
        idle();
        m_flags_s = 4'b0000; m_flags_m = 4'b0000; m_q_s = 1'b0; m_q_m = 1'b0;
        #2;
        chk("por flags_s", Flags_s, 4'b0000);
        chk("por condexq_m", CondExQ_m, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // ---- reset mid-cycle after flags and CondExQ were made non-zero
        set_flags(4'b1010);
        RegW = 1'b1;
        #1;
        chk("pre-rst regwr_m", RegWrite_m, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        m_flags_s = 4'b0000; m_flags_m = 4'b0000; m_q_s = 1'b0; m_q_m = 1'b0;
        chk("rst flags_s", Flags_s, 4'b0000);
        chk("rst flags_m", Flags_m, 4'b0000);
        chk("rst condexq_m", CondExQ_m, 1'b0);
        chk("rst regwr_m drop", RegWrite_m, 1'b0);
        chk("rst AL condex_s", CondEx_s, 1'b1);
        chk("rst AL regwr_s", RegWrite_s, 1'b1);
        Cond = 4'b0000;
        #1;
        chk("rst EQ condex_s", CondEx_s, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle();

        // ---- partial flag updates
        CondLatch = 1'b1;
        tick();
        CondLatch = 1'b0; FlagW = 2'b10; ALUFlags = 4'b1111;
        tick();
        chk("partial nz flags_s", Flags_s, 4'b1100);
        chk("partial nz flags_m", Flags_m, 4'b1100);
        FlagW = 2'b01; ALUFlags = 4'b0011;
        tick();
        chk("partial cv flags_s", Flags_s, 4'b1111);
        chk("partial cv flags_m", Flags_m, 4'b1111);

        // ---- failed condition blocks strobes and flag writes
        set_flags(4'b0000);
        Cond = 4'b0000; FlagW = 2'b11; ALUFlags = 4'b0100;
        RegW = 1'b1; MemW = 1'b1; PCS = 1'b1;
        #1;
        chk("fail pcsrc_s", PCSrc_s, 1'b0);
        chk("fail regwr_s", RegWrite_s, 1'b0);
        chk("fail memwr_s", MemWrite_s, 1'b0);
        check_all("fail");
        tick();
        chk("fail flags_s hold", Flags_s, 4'b0000);
        idle();

        // ---- condition table vectors
        foreach (tbl[i]) begin
            set_flags(tbl[i].flags);
            Cond = tbl[i].cond;
            #1;
            chk($sformatf("tbl[%0d] condex_s", i), CondEx_s, tbl[i].exp);
        end

        // ---- sweep signed compares and the reserved code over all flag values
        for (int f = 0; f < 16; f++) begin
            set_flags(f[3:0]);
            for (int c = 10; c < 16; c++) begin
                if (c == 14) continue;
                Cond = c[3:0];
                #1;
                chk($sformatf("sweep f=%0d c=%0d", f, c), CondEx_s, ref_pass(c[3:0], f[3:0]));
            end
        end

        // ---- multicycle: latched pass survives a later flag change
        set_flags(4'b0100);
        Cond = 4'b0000; CondLatch = 1'b1;
        tick();
        chk("mc latch condexq_m", CondExQ_m, 1'b1);
        CondLatch = 1'b0; Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b0000;
        tick();
        chk("mc flags_m cleared", Flags_m, 4'b0000);
        chk("mc condexq_m hold", CondExQ_m, 1'b1);
        Cond = 4'b0000; FlagW = 2'b00;
        tick();
        tick();
        RegW = 1'b1;
        #1;
        chk("mc wb condex_m", CondEx_m, 1'b0);
        chk("mc wb regwr_m", RegWrite_m, 1'b1);
        check_all("mc wb");
        idle();

        // ---- simultaneous latch and flag write captures the old-flag result
        set_flags(4'b0100);
        Cond = 4'b0000; CondLatch = 1'b1; FlagW = 2'b11; ALUFlags = 4'b0000;
        tick();
        chk("sim condexq_s", CondExQ_s, 1'b1);
        chk("sim flags_s", Flags_s, 4'b0000);
        chk("sim condex_s", CondEx_s, 1'b0);
        idle();

        // ---- stall: no writes, no strobes, CondLatch still honoured
        set_flags(4'b0101);
        InstrEn = 1'b0; FlagW = 2'b11; ALUFlags = 4'b1010;
        PCS = 1'b1; RegW = 1'b1; MemW = 1'b1;
        #1;
        chk("stall pcsrc_s", PCSrc_s, 1'b0);
        chk("stall regwr_s", RegWrite_s, 1'b0);
        chk("stall memwr_m", MemWrite_m, 1'b0);
        tick();
        chk("stall flags_s", Flags_s, 4'b0101);
        chk("stall flags_m", Flags_m, 4'b0101);
        Cond = 4'b0001; CondLatch = 1'b1;
        tick();
        chk("stall latch condexq_s", CondExQ_s, 1'b0);
        idle();

        // ---- NoWrite suppresses RegWrite only
        NoWrite = 1'b1; RegW = 1'b1; FlagW = 2'b11; ALUFlags = 4'b0011;
        #1;
        chk("nowrite regwr_s", RegWrite_s, 1'b0);
        tick();
        chk("nowrite flags_s", Flags_s, 4'b0011);
        idle();

        // ---- randomized run against the model
        for (int k = 0; k < 3000; k++) begin
            Cond      = 4'($urandom);
            ALUFlags  = 4'($urandom);
            FlagW     = 2'($urandom);
            PCS       = 1'($urandom);
            RegW      = 1'($urandom);
            MemW      = 1'($urandom);
            NoWrite   = ($urandom_range(0, 3) == 0);
            InstrEn   = ($urandom_range(0, 4) != 0);
            CondLatch = ($urandom_range(0, 2) == 0);
            #1;
            check_all("rand");
            if ($urandom_range(0, 199) == 0) begin
                rst_n = 1'b0;
                #1;
                m_flags_s = 4'b0000; m_flags_m = 4'b0000; m_q_s = 1'b0; m_q_m = 1'b0;
                check_all("rand rst");
                rst_n = 1'b1;
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
